// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard of in-flight register writes; stalls the ID instruction
// until each source operand can be forwarded to the stage that consumes it.
module hazard_scoreboard #(
   parameter int unsigned REG_BITS    = 5,
   parameter int unsigned ALU_LAT     = 1,
   parameter int unsigned LOAD_LAT    = 2,
   parameter int unsigned SLACK_EX    = 1,
   parameter int unsigned SLACK_MEM   = 2,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic                     id_flush,
   input  logic [5:0]               id_op,
   input  logic [REG_BITS-1:0]      id_rs,
   input  logic [REG_BITS-1:0]      id_rt,
   input  logic [REG_BITS-1:0]      id_rd,
   output logic                     stall,
   output logic [2**REG_BITS-1:0]   busy,
   output logic [STALL_CNT_W-1:0]   stall_cycles
);

   localparam int unsigned NREG    = 2**REG_BITS;
   localparam int unsigned MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [NREG-1:0][CNT_W-1:0] cnt;

   logic                rs_used, rt_used;
   logic [31:0]         rs_slack, rt_slack;
   logic                wr_en;
   logic [REG_BITS-1:0] wr_dst;
   logic [CNT_W-1:0]    wr_lat;
   logic                rs_hot, rt_hot, issue;

   // Operand usage, consumer slack and destination per opcode
   always_comb begin
      rs_used  = 1'b0;
      rt_used  = 1'b0;
      rs_slack = 32'(SLACK_EX);
      rt_slack = 32'(SLACK_EX);
      wr_en    = 1'b0;
      wr_dst   = id_rd;
      wr_lat   = CNT_W'(ALU_LAT);
      case (id_op)
         OP_RTYPE: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            wr_en   = 1'b1;
         end
         OP_ADDI: begin
            rs_used = 1'b1;
            wr_en   = 1'b1;
            wr_dst  = id_rt;
         end
         OP_LW: begin
            rs_used = 1'b1;
            wr_en   = 1'b1;
            wr_dst  = id_rt;
            wr_lat  = CNT_W'(LOAD_LAT);
         end
         OP_SW: begin
            rs_used  = 1'b1;
            rt_used  = 1'b1;
            rt_slack = 32'(SLACK_MEM);
         end
         OP_BEQ, OP_BNE: begin
            rs_used  = 1'b1;
            rt_used  = 1'b1;
            rs_slack = 32'd0;
            rt_slack = 32'd0;
         end
         default: ;
      endcase
   end

   // r0 is never loaded, so its counter is always zero and never stalls
   always_comb begin
      rs_hot = rs_used && (32'(cnt[id_rs]) > rs_slack);
      rt_hot = rt_used && (32'(cnt[id_rt]) > rt_slack);
      stall  = id_valid && !id_flush && (rs_hot || rt_hot);
      issue  = id_valid && !id_flush && !stall;
   end

   // Drain every counter each cycle; an issuing writer reloads its destination
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) begin
            if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
         end
         if (issue && wr_en && (wr_dst != '0)) cnt[wr_dst] <= wr_lat;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < int'(NREG); i++) busy[i] = |cnt[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: ready-time model checked every cycle plus
// directed hazard scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

   localparam int SCW      = 8;
   localparam int NREG     = 32;
   localparam int ALU_LAT  = 1;
   localparam int LOAD_LAT = 2;
   localparam int SL_EX    = 1;
   localparam int SL_MEM   = 2;
   localparam int SC_MAX   = (1 << SCW) - 1;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] BNE   = 6'b000101;
   localparam logic [5:0] JMP   = 6'b000010;
   localparam logic [5:0] ADDI  = 6'b001000;

   logic            clk, reset;
   logic            id_valid, id_flush;
   logic [5:0]      id_op;
   logic [4:0]      id_rs, id_rt, id_rd;
   logic            stall;
   logic [31:0]     busy;
   logic [SCW-1:0]  stall_cycles;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model: absolute cycle at which each register's value becomes forwardable
   int now = 0;
   int ready [NREG];
   int m_sc  = 0;

   hazard_scoreboard #(.STALL_CNT_W(SCW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
      .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .stall(stall), .busy(busy), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int remaining(input int r);
      if (r == 0) return 0;
      return (ready[r] > now) ? ready[r] - now : 0;
   endfunction

   function automatic bit model_stall();
      int a, b;
      if (!id_valid || id_flush) return 1'b0;
      a = remaining(int'(id_rs));
      b = remaining(int'(id_rt));
      case (id_op)
         RTYPE:      return (a > SL_EX) || (b > SL_EX);
         ADDI, LW:   return a > SL_EX;
         SW:         return (a > SL_EX) || (b > SL_MEM);
         BEQ, BNE:   return (a > 0) || (b > 0);
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] v = '0;
      for (int r = 1; r < NREG; r++) v[r] = (remaining(r) != 0);
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      bit st;
      int d, lat;
      if (reset) begin
         for (int r = 0; r < NREG; r++) ready[r] = 0;
         m_sc = 0;
      end else begin
         st = model_stall();
         if (st && m_sc < SC_MAX) m_sc++;
         d = 0;
         lat = 0;
         case (id_op)
            RTYPE: begin d = int'(id_rd); lat = ALU_LAT;  end
            ADDI:  begin d = int'(id_rt); lat = ALU_LAT;  end
            LW:    begin d = int'(id_rt); lat = LOAD_LAT; end
            default: ;
         endcase
         if (id_valid && !id_flush && !st && d != 0) ready[d] = now + 1 + lat;
         now++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_stall", 32'(stall), 32'(model_stall()));
         chk("model_busy", busy, model_busy());
         chk("model_stall_cycles", 32'(stall_cycles), 32'(m_sc));
      end
   end

   task automatic drive(input logic v, input logic f, input logic [5:0] op,
                        input int rs, input int rt, input int rd);
      @(posedge clk);
      #1;
      id_valid = v;
      id_flush = f;
      id_op    = op;
      id_rs    = 5'(rs);
      id_rt    = 5'(rt);
      id_rd    = 5'(rd);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, JMP, 0, 0, 0);
   endtask

   logic [5:0] ops [8];

   initial begin
      ops[0] = RTYPE; ops[1] = LW;  ops[2] = SW;   ops[3] = BEQ;
      ops[4] = BNE;   ops[5] = JMP; ops[6] = ADDI; ops[7] = 6'b111111;
      reset = 1'b1;
      id_valid = 1'b0; id_flush = 1'b0; id_op = JMP;
      id_rs = '0; id_rt = '0; id_rd = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("reset_stall", 32'(stall), 0);
      chk("reset_busy", busy, 0);
      chk("reset_sc", 32'(stall_cycles), 0);
      chk_en = 1'b1;

      // ALU producer then branch: one stall cycle
      drive(1, 0, ADDI, 1, 5, 0);
      chk("addi_issue", 32'(stall), 0);
      drive(1, 0, BEQ, 5, 0, 0);
      chk("beq_alu_stall", 32'(stall), 1);
      chk("busy5_set", 32'(busy[5]), 1);
      drive(1, 0, BEQ, 5, 0, 0);
      chk("beq_alu_go", 32'(stall), 0);
      chk("busy5_clear", 32'(busy[5]), 0);
      chk("sc_after_alu", 32'(stall_cycles), 1);

      // Load then branch: two stall cycles
      drive(1, 0, LW, 0, 7, 0);
      drive(1, 0, BNE, 0, 7, 0);
      chk("bne_lw_stall1", 32'(stall), 1);
      drive(1, 0, BNE, 0, 7, 0);
      chk("bne_lw_stall2", 32'(stall), 1);
      drive(1, 0, BNE, 0, 7, 0);
      chk("bne_lw_go", 32'(stall), 0);
      chk("sc_after_lw", 32'(stall_cycles), 3);

      // Load then EX consumer, SW data, SW base
      drive(1, 0, LW, 0, 9, 0);
      drive(1, 0, RTYPE, 9, 0, 10);
      chk("rtype_lw_stall", 32'(stall), 1);
      drive(1, 0, RTYPE, 9, 0, 10);
      chk("rtype_lw_go", 32'(stall), 0);
      drive(1, 0, LW, 0, 9, 0);
      drive(1, 0, SW, 0, 9, 0);
      chk("sw_data_nostall", 32'(stall), 0);
      drive(1, 0, LW, 0, 9, 0);
      drive(1, 0, SW, 9, 0, 0);
      chk("sw_base_stall", 32'(stall), 1);
      drive(1, 0, SW, 9, 0, 0);
      chk("sw_base_go", 32'(stall), 0);
      chk("sc_after_sw", 32'(stall_cycles), 5);

      // Writes to r0 are ignored
      repeat (3) idle();
      drive(1, 0, RTYPE, 0, 0, 0);
      drive(1, 0, BEQ, 0, 0, 0);
      chk("r0_nostall", 32'(stall), 0);
      chk("r0_busy", busy, 0);

      // Flush suppresses stall; reload beats decrement
      drive(1, 0, LW, 0, 3, 0);
      drive(1, 1, BEQ, 3, 0, 0);
      chk("flush_nostall", 32'(stall), 0);
      drive(1, 0, RTYPE, 0, 0, 3);
      chk("busy3_cnt1", 32'(busy[3]), 1);
      idle();
      chk("busy3_reload", 32'(busy[3]), 1);
      idle();
      chk("busy3_drain", 32'(busy[3]), 0);
      drive(1, 1, LW, 0, 12, 0);
      idle();
      chk("flushed_lw_nobusy", 32'(busy[12]), 0);

      // Reset in the middle of a stall
      drive(1, 0, LW, 0, 4, 0);
      drive(1, 0, BEQ, 4, 0, 0);
      chk("pre_reset_stall", 32'(stall), 1);
      reset = 1'b1;
      #1;
      chk("reset_mid_stall", 32'(stall), 0);
      chk("reset_mid_busy", busy, 0);
      chk("reset_mid_sc", 32'(stall_cycles), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle();

      // Mixed traffic cross-checked by the model
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
               ops[$urandom_range(0, 7)], int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      // Saturate the stall counter: 2 stalls per load/branch pair
      for (int i = 0; i < 140; i++) begin
         drive(1, 0, LW, 0, 6, 0);
         repeat (3) drive(1, 0, BEQ, 6, 0, 0);
      end
      idle();
      chk("sc_saturated", 32'(stall_cycles), 32'(SC_MAX));

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational stall detector.
- Keeps a per-register countdown scoreboard of in-flight writes. It raises a stall for the instruction in ID until every source operand it reads can be forwarded to the stage that consumes it.
- Producer latencies and consumer slacks are parameters, so the same block serves deeper or longer-latency pipelines.
- Sits beside the ID stage. Drives the PC/IF-ID hold and the ID-EX bubble insert.

Parameters:
- REG_BITS, 5, register index width; the scoreboard holds 2**REG_BITS entries.
- ALU_LAT, 1, cycles after issue until an RTYPE/ADDI result can be forwarded to ID.
- LOAD_LAT, 2, cycles after issue until an LW result can be forwarded to ID.
- SLACK_EX, 1, cycles of producer latency hidden for operands consumed in EX.
- SLACK_MEM, 2, cycles of producer latency hidden for operands consumed in MEM (SW store data).
- STALL_CNT_W, 16, width of the performance stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_flush  in  1  instruction in ID is squashed this cycle (taken branch or jump).
- id_op  in  6  opcode in ID.
- id_rs  in  REG_BITS  rs field in ID.
- id_rt  in  REG_BITS  rt field in ID.
- id_rd  in  REG_BITS  rd field in ID.
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
- busy  out  2**REG_BITS  bit r = 1 when cnt[r] != 0.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall = 1.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, ADDI 001000.
- Operand usage and consumer slack:
  - RTYPE: reads rs and rt (slack SLACK_EX); writes rd (lat ALU_LAT).
  - ADDI: reads rs (SLACK_EX); writes rt (ALU_LAT).
  - LW: reads rs (SLACK_EX); writes rt (LOAD_LAT).
  - SW: reads rs (SLACK_EX) and rt (SLACK_MEM); writes nothing.
  - BEQ/BNE: read rs and rt (slack 0); write nothing.
  - J and any unlisted opcode: read nothing, write nothing.
- State: cnt[r] for each register r, width clog2(max(ALU_LAT, LOAD_LAT) + 1). Reset sets every cnt to 0 and stall_cycles to 0.
- Register 0: never marked busy and never causes a stall; writes to r0 are ignored.
- Stall is combinational from current state and ID inputs:
  - stall = id_valid & ~id_flush & (some source s, s != 0, has cnt[s] > slack(s)).
  - id_flush has priority over stall: a squashed instruction never stalls.
- issue = id_valid & ~id_flush & ~stall.
- Every rising edge:
  - Every nonzero cnt decrements by 1, saturating at 0.
  - Then, if issue and the instruction writes a nonzero dest, cnt[dest] is loaded with that instruction's lat.
  - Load wins over decrement on the same entry.
- A stalled or flushed instruction does not touch the scoreboard. Counters keep draining during stalls.
- stall_cycles increments on each edge where stall = 1 and holds at all-ones.
- busy reflects registered state only; it has no combinational path from the ID inputs.
- Reset mid-stall: stall drops to 0 immediately, because all cnt are 0 asynchronously.
- Default timing:
  - A branch directly after an ALU producer sees 1 stall cycle; after LW, 2.
  - An ALU consumer directly after LW sees 1 stall cycle; after an ALU producer, 0.
  - SW data directly after LW sees 0 stall cycles.

Test Plan:
- Reset, then issue ADDI rt=5. Next cycle BEQ rs=5 -> stall = 1 for exactly 1 cycle, busy[5] = 1 then 0, stall_cycles = 1.
- Issue LW rt=7, then BNE rt=7 -> stall = 1 for 2 cycles, then the BNE issues; stall_cycles increases by 2.
- Issue LW rt=9, then RTYPE rs=9 -> 1 stall cycle. Repeat with SW rt=9 (data operand) -> 0 stall cycles. Repeat with SW rs=9 (base) -> 1 stall cycle.
- Issue RTYPE rd=0, then BEQ rs=0 -> no stall, busy = 0.
- Issue LW rt=3; next cycle assert id_flush on BEQ rs=3 -> stall = 0 and the BEQ does not issue. Issue RTYPE rd=3 while cnt[3] = 1 -> cnt[3] reloads to 1 (load wins over decrement).
- Assert reset while stall = 1 after an LW -> stall and busy = 0 immediately, stall_cycles = 0. Separately, force more than 2**STALL_CNT_W stall cycles -> stall_cycles saturates at all-ones.
